// File: rtl/tdes_ahb_top.sv
// ---------------------------------------------------------------------------
// tdes_ahb_top : AHB-Lite slave around a pipelined Triple-DES (EDE) engine.
//
// The bus master writes MODE, KEY1..KEY3 and DIN; every DIN write launches one
// 3DES block through tdes_core. The result lands in DOUT and raises STAT[0],
// which is cleared by a DOUT read.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL, HREADY          transfer qualification (address phase)
//   HWRITE, HADDR         address-phase direction and byte address
//   HTRANS, HBURST,
//   HSIZE, HPROT,
//   HMASTLOCK             accepted but unused; every access is a 64-bit single
//   HWDATA                write data (data phase)
//   HRDATA                read data (data phase, combinational)
//   HRESP                 tied to OKAY
//
// tdes_core : three-stage pipelined 3DES, one full DES per stage, with an
// optional extra output delay so that valid trails start by exactly LAT cycles.
//   clk, rst, start, enc, k1, k2, k3, din  ->  dout, valid
// ---------------------------------------------------------------------------

module tdes_core #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        enc,
    input  logic [63:0] k1,
    input  logic [63:0] k2,
    input  logic [63:0] k3,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic        valid
);

    // PC-2 and P permutation tables, one byte per entry, DES 1-based bit numbers.
    localparam logic [383:0] PC2_T = {
        64'h0E110B180105031C, 64'h0F06150A17130C04, 64'h1A0810071B140D02,
        64'h29341F252F371E28, 64'h332D21302C312738, 64'h22352E2A32241D20};
    localparam logic [255:0] P_T = {
        64'h100714151D0C1C11, 64'h010F171A05121F0A,
        64'h0208180E201B0309, 64'h130D1E06160B0419};

    // S1..S8, each 64 nibbles in row-major order.
    localparam logic [2047:0] SBOX_T = {
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    // DES bit n (1 = MSB) of a W-bit vector v is v[W-n] throughout.
    function automatic int ipSrc(input int i);
        return ((i / 8) < 4 ? 58 + 2 * (i / 8) : 49 + 2 * (i / 8)) - 8 * (i % 8);
    endfunction

    // Single DES block; parity bits of the key are dropped by PC-1.
    function automatic logic [63:0] desBlock(input logic [63:0] blk,
                                             input logic [63:0] key,
                                             input logic        dec);
        logic [47:0] ks [16];
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [63:0] ip;
        logic [63:0] pre;
        logic [63:0] res;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] s;
        logic [31:0] f;
        logic [31:0] tmp;
        logic [47:0] e;
        logic [47:0] x;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 64; i++) begin
            ip[63 - i] = blk[64 - ipSrc(i)];
        end
        // PC-1 split into the C and D halves.
        for (int i = 0; i < 28; i++) begin
            c[27 - i] = key[64 - (57 + i / 8 - 8 * (i % 8))];
            d[27 - i] = key[64 - ((i < 24) ? (63 - i / 8 - 8 * (i % 8)) : (28 - 8 * (i % 8)))];
        end
        for (int n = 0; n < 16; n++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
            if (!(n == 0 || n == 1 || n == 8 || n == 15)) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) begin
                ks[n][47 - j] = cd[56 - int'(PC2_T[383 - 8 * j -: 8])];
            end
        end
        l = ip[63:32];
        r = ip[31:0];
        for (int n = 0; n < 16; n++) begin
            // E expansion: groups of six overlapping the neighbouring nibbles.
            for (int j = 0; j < 48; j++) begin
                e[47 - j] = r[32 - (((4 * (j / 6) + j % 6 + 31) % 32) + 1)];
            end
            x = e ^ (dec ? ks[15 - n] : ks[n]);
            for (int b = 0; b < 8; b++) begin
                six = x[47 - 6 * b -: 6];
                idx = int'({six[5], six[0], six[4:1]});
                s[31 - 4 * b -: 4] = SBOX_T[2047 - 256 * b - 4 * idx -: 4];
            end
            for (int j = 0; j < 32; j++) begin
                f[31 - j] = s[32 - int'(P_T[255 - 8 * j -: 8])];
            end
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        pre = {r, l};
        res = 64'd0;
        // Final permutation is the inverse of IP, done as a scatter.
        for (int i = 0; i < 64; i++) begin
            res[64 - ipSrc(i)] = pre[63 - i];
        end
        return res;
    endfunction

    logic        v1, v2, v3;
    logic [63:0] d1, d2, d3;
    logic        enc1, enc2;
    logic [63:0] k2s1;
    logic [63:0] kLast1, kLast2;

    // EDE pipeline: each stage carries the mode and keys it still needs, so
    // later MODE/KEY writes never reach a block already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;  v2 <= 1'b0;  v3 <= 1'b0;
            d1 <= 64'd0; d2 <= 64'd0; d3 <= 64'd0;
            enc1 <= 1'b0; enc2 <= 1'b0;
            k2s1 <= 64'd0; kLast1 <= 64'd0; kLast2 <= 64'd0;
        end else begin
            v1     <= start;
            d1     <= desBlock(din, enc ? k1 : k3, ~enc);
            enc1   <= enc;
            k2s1   <= k2;
            kLast1 <= enc ? k3 : k1;
            v2     <= v1;
            d2     <= desBlock(d1, k2s1, enc1);
            enc2   <= enc1;
            kLast2 <= kLast1;
            v3     <= v2;
            d3     <= desBlock(d2, kLast2, ~enc2);
        end
    end

    generate
        if (LAT > 3) begin : gDelay
            logic [63:0] dq [LAT-3];
            logic        vq [LAT-3];
            // Pads the pipeline out to the configured latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT - 3; i++) begin
                        dq[i] <= 64'd0;
                        vq[i] <= 1'b0;
                    end
                end else begin
                    dq[0] <= d3;
                    vq[0] <= v3;
                    for (int i = 1; i < LAT - 3; i++) begin
                        dq[i] <= dq[i-1];
                        vq[i] <= vq[i-1];
                    end
                end
            end
            assign dout  = dq[LAT-4];
            assign valid = vq[LAT-4];
        end else begin : gDirect
            assign dout  = d3;
            assign valid = v3;
        end
    endgenerate

endmodule

module tdes_ahb_top #(
    parameter logic [31:0] BASE_ADDR = 32'hAAAAAAA0,
    parameter int          CORE_LAT  = 3
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HRESP
);

    localparam logic [31:0] ADDR_MODE = BASE_ADDR + 32'h0;
    localparam logic [31:0] ADDR_KEY1 = BASE_ADDR + 32'h1;
    localparam logic [31:0] ADDR_KEY2 = BASE_ADDR + 32'h2;
    localparam logic [31:0] ADDR_KEY3 = BASE_ADDR + 32'h3;
    localparam logic [31:0] ADDR_DIN  = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_DOUT = BASE_ADDR + 32'h8;
    localparam logic [31:0] ADDR_STAT = BASE_ADDR + 32'h9;

    logic        aValid;
    logic        aWrite;
    logic [31:0] aAddr;
    logic        modeReg;
    logic [63:0] key1Reg, key2Reg, key3Reg;
    logic [63:0] dinReg;
    logic [63:0] doutReg;
    logic        resultValid;
    logic        startReg;
    logic [63:0] coreDout;
    logic        coreValid;
    logic [63:0] rdata;
    logic        doutRead;

    // Transfer attributes are not used: all accesses are 64-bit singles.
    logic unusedBits;
    assign unusedBits = ^{HTRANS, HBURST, HSIZE, HPROT, HMASTLOCK};

    assign doutRead = aValid & ~aWrite & (aAddr == ADDR_DOUT);

    // Address-phase capture; the data phase follows on the next cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            aValid <= 1'b0;
            aWrite <= 1'b0;
            aAddr  <= 32'd0;
        end else begin
            aValid <= HSEL & HREADY;
            aWrite <= HWRITE;
            aAddr  <= HADDR;
        end
    end

    // Write data phase into the configuration registers; DIN fires the core.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            modeReg  <= 1'b0;
            key1Reg  <= 64'd0;
            key2Reg  <= 64'd0;
            key3Reg  <= 64'd0;
            dinReg   <= 64'd0;
            startReg <= 1'b0;
        end else begin
            startReg <= 1'b0;
            if (aValid && aWrite) begin
                case (aAddr)
                    ADDR_MODE: modeReg <= HWDATA[0];
                    ADDR_KEY1: key1Reg <= HWDATA;
                    ADDR_KEY2: key2Reg <= HWDATA;
                    ADDR_KEY3: key3Reg <= HWDATA;
                    ADDR_DIN: begin
                        dinReg   <= HWDATA;
                        startReg <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Result capture; a completion in the same cycle as a DOUT read wins, so
    // the new result is never reported as already consumed.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            doutReg     <= 64'd0;
            resultValid <= 1'b0;
        end else if (coreValid) begin
            doutReg     <= coreDout;
            resultValid <= 1'b1;
        end else if (doutRead) begin
            resultValid <= 1'b0;
        end
    end

    // Read data mux; zero outside a read data phase and while in reset.
    always_comb begin
        rdata = 64'd0;
        if (aValid && !aWrite && !HRESET) begin
            case (aAddr)
                ADDR_MODE: rdata = {63'd0, modeReg};
                ADDR_DOUT: rdata = doutReg;
                ADDR_STAT: rdata = {63'd0, resultValid};
                default:   rdata = 64'd0;
            endcase
        end else begin
            rdata = 64'd0;
        end
    end

    assign HRDATA = rdata;
    assign HRESP  = 1'b0;

    tdes_core #(
        .LAT (CORE_LAT)
    ) uCore (
        .clk   (HCLK),
        .rst   (HRESET),
        .start (startReg),
        .enc   (modeReg),
        .k1    (key1Reg),
        .k2    (key2Reg),
        .k3    (key3Reg),
        .din   (dinReg),
        .dout  (coreDout),
        .valid (coreValid)
    );

endmodule

// File: tb/tb_tdes_ahb_top.sv
module tb_tdes_ahb_top;

    localparam logic [31:0] BASE      = 32'hAAAAAAA0;
    localparam logic [31:0] ADDR_MODE = BASE + 32'h0;
    localparam logic [31:0] ADDR_KEY1 = BASE + 32'h1;
    localparam logic [31:0] ADDR_KEY2 = BASE + 32'h2;
    localparam logic [31:0] ADDR_KEY3 = BASE + 32'h3;
    localparam logic [31:0] ADDR_DIN  = BASE + 32'h4;
    localparam logic [31:0] ADDR_DOUT = BASE + 32'h8;
    localparam logic [31:0] ADDR_STAT = BASE + 32'h9;
    localparam logic [63:0] KEY_A     = 64'h133457799BBCDFF1;
    localparam logic [63:0] PLAIN_A   = 64'h0123456789ABCDEF;
    localparam logic [63:0] CIPHER_A  = 64'h85E813540F0AB405;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic        HREADY;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HRESP;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] expQ [$];
    logic [63:0] lastRdata;
    logic        lastResp;

    tdes_ahb_top dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    // One bus cycle: new address phase + data for the previous transfer.
    task automatic busCycle(input logic sel, input logic wr, input logic [31:0] addr,
                            input logic [63:0] wdata);
        HSEL   = sel;
        HWRITE = wr;
        HADDR  = addr;
        HWDATA = wdata;
        @(negedge HCLK);
        lastRdata = HRDATA;
        lastResp  = HRESP;
        @(posedge HCLK);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [63:0] data);
        busCycle(1'b1, 1'b1, addr, 64'd0);
        busCycle(1'b0, 1'b0, 32'd0, data);
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [63:0] data);
        busCycle(1'b1, 1'b0, addr, 64'd0);
        busCycle(1'b0, 1'b0, 32'd0, 64'd0);
        data = lastRdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) busCycle(1'b0, 1'b0, 32'd0, 64'd0);
    endtask

    task automatic setup(input logic mode, input logic [63:0] k1, input logic [63:0] k2,
                         input logic [63:0] k3);
        busWrite(ADDR_MODE, {63'd0, mode});
        busWrite(ADDR_KEY1, k1);
        busWrite(ADDR_KEY2, k2);
        busWrite(ADDR_KEY3, k3);
    endtask

    task automatic test_reset();
        logic [63:0] v;
        HRESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            busCycle(1'b1, 1'b0, ADDR_STAT, 64'd0);
            checks++;
            if (lastRdata !== 64'd0 || lastResp !== 1'b0) begin
                errors++;
                $display("FAIL reset_bus: HRDATA=%h HRESP=%b, expected 0/0", lastRdata, lastResp);
            end
        end
        HRESET = 1'b0;
        busRead(ADDR_STAT, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_stat: got %h expected 0", v); end
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", v); end
        busRead(ADDR_MODE, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL reset_mode: got %h expected 0", v); end
    endtask

    task automatic test_encrypt();
        logic [63:0] v;
        setup(1'b1, KEY_A, KEY_A, KEY_A);
        busWrite(ADDR_DIN, PLAIN_A);
        expQ.push_back(CIPHER_A);
        idle(3);
        busRead(ADDR_STAT, v);
        checks++;
        if (v !== 64'd1) begin errors++; $display("FAIL enc_stat_set: got %h expected 1", v); end
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL enc_dout: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
        busRead(ADDR_STAT, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL enc_stat_clr: got %h expected 0", v); end
        checks++;
        if (lastResp !== 1'b0) begin errors++; $display("FAIL enc_hresp: got %b expected 0", lastResp); end
    endtask

    task automatic test_decrypt();
        logic [63:0] v;
        setup(1'b0, KEY_A, KEY_A, KEY_A);
        busWrite(ADDR_DIN, CIPHER_A);
        expQ.push_back(PLAIN_A);
        idle(3);
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL dec_dout: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
    endtask

    task automatic test_roundtrip();
        logic [63:0] c;
        logic [63:0] v;
        setup(1'b1, 64'h4444444444444444, 64'h4444444444444444, 64'h6666666666666666);
        busWrite(ADDR_DIN, 64'h9999999999999999);
        idle(3);
        busRead(ADDR_DOUT, c);
        checks++;
        if (c === 64'h9999999999999999) begin
            errors++; $display("FAIL rt_cipher_changed: got %h expected a different value", c);
        end
        busWrite(ADDR_MODE, 64'd0);
        busWrite(ADDR_DIN, c);
        expQ.push_back(64'h9999999999999999);
        idle(3);
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL rt_plain: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [63:0] prev;
        logic [63:0] x88;
        logic [63:0] xaa;
        logic [63:0] v;
        setup(1'b1, KEY_A, KEY_A, KEY_A);
        prev = 64'd0;
        for (int i = 4; i <= 8; i++) begin
            busCycle(1'b1, 1'b1, ADDR_DIN, prev);
            prev = {16{4'(i)}};
        end
        busCycle(1'b0, 1'b0, 32'd0, prev);
        idle(3);
        busRead(ADDR_STAT, v);
        checks++;
        if (v !== 64'd1) begin errors++; $display("FAIL stream_stat: got %h expected 1", v); end
        busRead(ADDR_DOUT, x88);
        busWrite(ADDR_DIN, 64'hAAAAAAAAAAAAAAAA);
        idle(3);
        busRead(ADDR_DOUT, xaa);
        checks++;
        if (xaa === x88) begin errors++; $display("FAIL stream_distinct: got %h, same as previous", xaa); end
        // Decrypting what the engine returned must give back the stream inputs.
        busWrite(ADDR_MODE, 64'd0);
        busWrite(ADDR_DIN, x88);
        expQ.push_back(64'h8888888888888888);
        idle(3);
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL stream_last: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
        busWrite(ADDR_DIN, xaa);
        expQ.push_back(64'hAAAAAAAAAAAAAAAA);
        idle(3);
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL stream_aa: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
    endtask

    task automatic test_coincide();
        logic [63:0] v;
        setup(1'b0, KEY_A, KEY_A, KEY_A);
        busWrite(ADDR_DIN, CIPHER_A);
        idle(3);
        busRead(ADDR_DOUT, v);
        busWrite(ADDR_MODE, 64'd1);
        busWrite(ADDR_DIN, PLAIN_A);
        expQ.push_back(PLAIN_A);
        expQ.push_back(CIPHER_A);
        idle(2);
        // This read's data phase lines up with the core valid cycle.
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL coinc_old: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
        busRead(ADDR_STAT, v);
        checks++;
        if (v !== 64'd1) begin errors++; $display("FAIL coinc_stat: got %h expected 1", v); end
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL coinc_new: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
    endtask

    task automatic test_inflight_params();
        logic [63:0] v;
        setup(1'b1, KEY_A, KEY_A, KEY_A);
        busWrite(ADDR_DIN, PLAIN_A);
        expQ.push_back(CIPHER_A);
        busWrite(ADDR_MODE, 64'd0);
        busWrite(ADDR_KEY3, 64'h0F0F0F0F0F0F0F0F);
        idle(1);
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL inflight: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
    endtask

    task automatic test_decode();
        logic [63:0] v;
        setup(1'b1, KEY_A, KEY_A, KEY_A);
        busWrite(32'h0, 64'd0);
        busCycle(1'b0, 1'b1, ADDR_MODE, 64'd0);
        busCycle(1'b0, 1'b0, 32'd0, 64'd0);
        busCycle(1'b0, 1'b1, ADDR_KEY1, 64'd0);
        busCycle(1'b0, 1'b0, 32'd0, 64'h1111111111111111);
        busRead(ADDR_MODE, v);
        checks++;
        if (v !== 64'd1) begin errors++; $display("FAIL dec_mode_kept: got %h expected 1", v); end
        busWrite(ADDR_DIN, PLAIN_A);
        expQ.push_back(CIPHER_A);
        idle(3);
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== expQ[0]) begin errors++; $display("FAIL dec_key_kept: got %h expected %h", v, expQ[0]); end
        void'(expQ.pop_front());
        busRead(ADDR_KEY1, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL key1_read: got %h expected 0", v); end
        busRead(ADDR_DIN, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL din_read: got %h expected 0", v); end
        busRead(BASE + 32'h5, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", v); end
        HTRANS = 2'b00;
        busWrite(ADDR_MODE, 64'd0);
        HTRANS = 2'b10;
        busRead(ADDR_MODE, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL htrans_idle_write: got %h expected 0", v); end
        busWrite(ADDR_MODE, 64'hFFFFFFFFFFFFFFFF);
        busRead(ADDR_MODE, v);
        checks++;
        if (v !== 64'd1) begin errors++; $display("FAIL mode_mask: got %h expected 1", v); end
    endtask

    task automatic test_reset_inflight();
        logic [63:0] v;
        setup(1'b1, KEY_A, KEY_A, KEY_A);
        busWrite(ADDR_DIN, PLAIN_A);
        HRESET = 1'b1;
        idle(1);
        HRESET = 1'b0;
        idle(4);
        busRead(ADDR_STAT, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL rst_inflight_stat: got %h expected 0", v); end
        busRead(ADDR_DOUT, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL rst_inflight_dout: got %h expected 0", v); end
    endtask

    initial begin
        HRESET    = 1'b1;
        HSEL      = 1'b0;
        HREADY    = 1'b1;
        HWRITE    = 1'b0;
        HADDR     = 32'd0;
        HTRANS    = 2'b10;
        HBURST    = 3'b000;
        HSIZE     = 3'b011;
        HPROT     = 4'b0011;
        HMASTLOCK = 1'b0;
        HWDATA    = 64'd0;
        @(posedge HCLK);
        #1;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_roundtrip();
        test_back_to_back();
        test_coincide();
        test_inflight_params();
        test_decode();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
